// File: rtl/filt_ppd_seq.sv
`default_nettype none
// ============================================================================
// filt_ppd_seq : polyphase decimator, one shared MAC over a D*T-tap line
// rev 1.0
// ============================================================================
module filt_ppd_seq #(
   parameter int gp_idata_width    = 6,
   parameter int gp_coeff_width    = 16,
   parameter int gp_max_decimation = 32,
   parameter int gp_max_taps_phase = 4,
   parameter int gp_odata_width    = 16,
   parameter int gp_acc_width      = gp_idata_width + gp_coeff_width
                                     + $clog2(gp_max_decimation * gp_max_taps_phase)
) (
   input  logic                                                   i_clk,
   input  logic                                                   i_rst,
   input  logic                                                   i_ena,
   input  logic                                                   i_cfg_load,
   input  logic [$clog2(gp_max_decimation+1)-1:0]                 i_cfg_dec,
   input  logic [$clog2(gp_max_taps_phase+1)-1:0]                 i_cfg_taps,
   input  logic [$clog2(gp_acc_width)-1:0]                        i_cfg_shift,
   input  logic                                                   i_coeff_we,
   input  logic [$clog2(gp_max_decimation*gp_max_taps_phase)-1:0] i_coeff_addr,
   input  logic [gp_coeff_width-1:0]                              i_coeff_data,
   input  logic                                                   i_valid,
   input  logic [gp_idata_width-1:0]                              i_data,
   output logic                                                   o_ready,
   output logic                                                   o_valid,
   output logic [gp_odata_width-1:0]                              o_data,
   output logic                                                   o_sat,
   output logic                                                   o_busy
);

   localparam int c_nmax = gp_max_decimation * gp_max_taps_phase;
   localparam int c_aw   = $clog2(c_nmax);
   localparam int c_nw   = $clog2(c_nmax + 1);
   localparam int c_dw   = $clog2(gp_max_decimation + 1);
   localparam int c_tw   = $clog2(gp_max_taps_phase + 1);
   localparam int c_sw   = $clog2(gp_acc_width);
   localparam int c_pw   = (gp_max_decimation > 1) ? $clog2(gp_max_decimation) : 1;
   localparam int c_mw   = gp_idata_width + gp_coeff_width;
   localparam int c_ew   = gp_acc_width + 1;

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_mac  = 2'd1;
   localparam logic [1:0] c_st_rnd  = 2'd2;
   localparam logic [1:0] c_st_out  = 2'd3;

   localparam logic signed [c_ew-1:0] c_omax =
      {{(c_ew-gp_odata_width+1){1'b0}}, {(gp_odata_width-1){1'b1}}};
   localparam logic signed [c_ew-1:0] c_omin =
      {{(c_ew-gp_odata_width+1){1'b1}}, {(gp_odata_width-1){1'b0}}};

   logic [1:0]                        r_state;
   logic [c_pw-1:0]                   r_phase;
   logic [c_pw-1:0]                   r_dec_m1;
   logic [c_aw-1:0]                   r_k;
   logic [c_aw-1:0]                   r_klast;
   logic [c_sw-1:0]                   r_shift;
   logic signed [gp_acc_width-1:0]    r_acc;
   logic                              r_valid;
   logic [gp_odata_width-1:0]         r_data;
   logic                              r_sat;
   logic signed [gp_idata_width-1:0]  r_x    [c_nmax];
   logic signed [gp_coeff_width-1:0]  r_coef [c_nmax];

   logic                              w_idle_en;
   logic                              w_load;
   logic                              w_accept;
   logic                              w_coef_we;
   logic                              w_addr_ok;
   logic [c_dw-1:0]                   w_dec;
   logic [c_tw-1:0]                   w_taps;
   logic [c_pw-1:0]                   w_dec_m1;
   logic [c_aw-1:0]                   w_klast;
   logic signed [gp_idata_width-1:0]  w_x;
   logic signed [gp_coeff_width-1:0]  w_h;
   logic signed [c_mw-1:0]            w_prod;
   logic signed [gp_acc_width-1:0]    w_prod_ext;
   logic signed [c_ew-1:0]            w_acc_ext;
   logic signed [c_ew-1:0]            w_half;
   logic signed [c_ew-1:0]            w_rnd_sum;
   logic signed [c_ew-1:0]            w_shifted;
   logic [gp_odata_width-1:0]         w_out;
   logic                              w_clip;

   assign w_idle_en = (r_state == c_st_idle) & i_ena;
   assign w_load    = w_idle_en & i_cfg_load;
   assign w_accept  = w_idle_en & i_valid & ~i_cfg_load;
   assign w_coef_we = w_idle_en & i_coeff_we & w_addr_ok;

   // The range check only exists when the address field can exceed the bank.
   generate
      if ((1 << c_aw) > c_nmax) begin : g_addr_chk
         assign w_addr_ok = (i_coeff_addr < c_aw'(c_nmax));
      end else begin : g_addr_full
         assign w_addr_ok = 1'b1;
      end
   endgenerate

   always_comb begin
      w_dec = i_cfg_dec;
      if (i_cfg_dec == '0)
         w_dec = c_dw'(1);
      else if (i_cfg_dec > c_dw'(gp_max_decimation))
         w_dec = c_dw'(gp_max_decimation);
      w_taps = i_cfg_taps;
      if (i_cfg_taps == '0)
         w_taps = c_tw'(1);
      else if (i_cfg_taps > c_tw'(gp_max_taps_phase))
         w_taps = c_tw'(gp_max_taps_phase);
   end

   assign w_dec_m1 = c_pw'(w_dec - c_dw'(1));
   assign w_klast  = c_aw'(c_nw'(w_dec) * c_nw'(w_taps) - c_nw'(1));

   assign w_x        = r_x[r_k];
   assign w_h        = r_coef[r_k];
   assign w_prod     = {{gp_coeff_width{w_x[gp_idata_width-1]}}, w_x}
                     * {{gp_idata_width{w_h[gp_coeff_width-1]}}, w_h};
   assign w_prod_ext = {{(gp_acc_width-c_mw){w_prod[c_mw-1]}}, w_prod};

   // Round half up, arithmetic shift, then clip into the output range.
   always_comb begin
      w_acc_ext = {r_acc[gp_acc_width-1], r_acc};
      w_half    = '0;
      if (r_shift != '0)
         w_half = c_ew'(1) << (r_shift - c_sw'(1));
      w_rnd_sum = w_acc_ext + w_half;
      w_shifted = w_rnd_sum >>> r_shift;
      w_out     = w_shifted[gp_odata_width-1:0];
      w_clip    = 1'b0;
      if (w_shifted > c_omax) begin
         w_out  = c_omax[gp_odata_width-1:0];
         w_clip = 1'b1;
      end else if (w_shifted < c_omin) begin
         w_out  = c_omin[gp_odata_width-1:0];
         w_clip = 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= c_st_idle;
         r_phase  <= '0;
         r_dec_m1 <= '0;
         r_k      <= '0;
         r_klast  <= '0;
         r_shift  <= '0;
         r_acc    <= '0;
         r_valid  <= 1'b0;
         r_data   <= '0;
         r_sat    <= 1'b0;
      end else if (i_ena) begin
         case (r_state)
            c_st_idle: begin
               if (i_cfg_load) begin
                  r_dec_m1 <= w_dec_m1;
                  r_klast  <= w_klast;
                  r_shift  <= i_cfg_shift;
                  r_phase  <= '0;
               end else if (i_valid) begin
                  if (r_phase == r_dec_m1) begin
                     r_phase <= '0;
                     r_acc   <= '0;
                     r_k     <= '0;
                     r_state <= c_st_mac;
                  end else begin
                     r_phase <= r_phase + c_pw'(1);
                  end
               end
            end
            c_st_mac: begin
               r_acc <= r_acc + w_prod_ext;
               r_k   <= r_k + c_aw'(1);
               if (r_k == r_klast)
                  r_state <= c_st_rnd;
            end
            c_st_rnd: begin
               r_data  <= w_out;
               r_sat   <= w_clip;
               r_valid <= 1'b1;
               r_state <= c_st_out;
            end
            c_st_out: begin
               r_valid <= 1'b0;
               r_state <= c_st_idle;
            end
            default: r_state <= c_st_idle;
         endcase
      end
   end

   // Newest sample lands in x[0]; a configuration load flushes the history.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < c_nmax; i++)
            r_x[i] <= '0;
      end else if (w_load) begin
         for (int i = 0; i < c_nmax; i++)
            r_x[i] <= '0;
      end else if (w_accept) begin
         r_x[0] <= i_data;
         for (int i = 1; i < c_nmax; i++)
            r_x[i] <= r_x[i-1];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < c_nmax; i++)
            r_coef[i] <= '0;
      end else if (w_coef_we) begin
         r_coef[i_coeff_addr] <= i_coeff_data;
      end
   end

   assign o_ready = (r_state == c_st_idle) & i_ena & ~i_rst;
   assign o_busy  = (r_state != c_st_idle);
   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_sat   = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_filt_ppd_seq.sv
`default_nettype none
// ============================================================================
// tb_filt_ppd_seq : scoreboard bench for the polyphase decimation filter
// rev 1.0
// ============================================================================
module tb_filt_ppd_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        ena;
   logic        cfg_load;
   logic [5:0]  cfg_dec;
   logic [2:0]  cfg_taps;
   logic [4:0]  cfg_shift;
   logic        coeff_we;
   logic [6:0]  coeff_addr;
   logic [15:0] coeff_data;
   logic        in_valid;
   logic [5:0]  in_data;
   logic        out_ready;
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_sat;
   logic        out_busy;

   always #5 clk = ~clk;

   filt_ppd_seq dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_ena        (ena),
      .i_cfg_load   (cfg_load),
      .i_cfg_dec    (cfg_dec),
      .i_cfg_taps   (cfg_taps),
      .i_cfg_shift  (cfg_shift),
      .i_coeff_we   (coeff_we),
      .i_coeff_addr (coeff_addr),
      .i_coeff_data (coeff_data),
      .i_valid      (in_valid),
      .i_data       (in_data),
      .o_ready      (out_ready),
      .o_valid      (out_valid),
      .o_data       (out_data),
      .o_sat        (out_sat),
      .o_busy       (out_busy)
   );

   typedef struct {
      longint data;
      longint sat;
   } exp_t;

   exp_t   sb_q[$];
   exp_t   mon_e;
   int     n_checks = 0;
   int     n_errors = 0;
   int     n_out    = 0;
   longint last_out = 0;
   longint last_sat = 0;
   logic   prev_v   = 1'b0;

   longint m_hist[128];
   longint m_coef[128];
   int     m_d     = 1;
   int     m_t     = 1;
   int     m_s     = 0;
   int     m_phase = 0;

   task automatic chk(input string tag, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic int clamp(input int v, input int mx);
      if (v == 0) return 1;
      if (v > mx) return mx;
      return v;
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 128; k++) begin
         m_hist[k] = 0;
         m_coef[k] = 0;
      end
      m_d = 1; m_t = 1; m_s = 0; m_phase = 0;
   endfunction

   // Reference: direct convolution of the newest D*T samples, round half up, clip.
   function automatic void push_exp();
      longint acc;
      longint v;
      exp_t   e;
      acc = 0;
      for (int k = 0; k < m_d * m_t; k++)
         acc += m_coef[k] * m_hist[k];
      v = acc;
      if (m_s > 0)
         v = v + (longint'(1) <<< (m_s - 1));
      v = v >>> m_s;
      e.sat = 0;
      if (v > 32767) begin
         v = 32767; e.sat = 1;
      end else if (v < -32768) begin
         v = -32768; e.sat = 1;
      end
      e.data = v;
      sb_q.push_back(e);
   endfunction

   function automatic void model_step();
      if (coeff_we)
         m_coef[coeff_addr] = longint'($signed(coeff_data));
      if (cfg_load) begin
         m_d = clamp(int'(cfg_dec), 32);
         m_t = clamp(int'(cfg_taps), 4);
         m_s = int'(cfg_shift);
         for (int k = 0; k < 128; k++)
            m_hist[k] = 0;
         m_phase = 0;
      end else if (in_valid) begin
         for (int k = 127; k > 0; k--)
            m_hist[k] = m_hist[k-1];
         m_hist[0] = longint'($signed(in_data));
         m_phase++;
         if (m_phase == m_d) begin
            m_phase = 0;
            push_exp();
         end
      end
   endfunction

   // Inputs only change just after posedge, so the negedge sees what the next edge will take.
   always @(negedge clk) begin
      if (rst) begin
         model_reset();
         sb_q.delete();
         prev_v = 1'b0;
      end else begin
         if (out_valid && !prev_v) begin
            n_out++;
            last_out = longint'($signed(out_data));
            last_sat = longint'(out_sat);
            chk("sb_pending", (sb_q.size() > 0) ? 1 : 0, 1);
            if (sb_q.size() > 0) begin
               mon_e = sb_q.pop_front();
               chk("out_data", last_out, mon_e.data);
               chk("out_sat", last_sat, mon_e.sat);
            end
         end
         prev_v = out_valid;
         if (out_ready)
            model_step();
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(output int lows);
      lows = 0;
      while (!out_ready && lows < 300) begin
         lows++;
         tick();
      end
      if (lows >= 300)
         chk("rdy_timeout", lows, 0);
   endtask

   task automatic send(input int v, output int lows);
      in_data = 6'(v);
      wait_ready(lows);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic cfg(input int d, input int t, input int s);
      int lows;
      wait_ready(lows);
      cfg_load  = 1'b1;
      cfg_dec   = 6'(d);
      cfg_taps  = 3'(t);
      cfg_shift = 5'(s);
      tick();
      cfg_load  = 1'b0;
   endtask

   task automatic wr_coef(input int a, input int d);
      int lows;
      wait_ready(lows);
      coeff_we   = 1'b1;
      coeff_addr = 7'(a);
      coeff_data = 16'(d);
      tick();
      coeff_we   = 1'b0;
   endtask

   // Counts sample points with o_ready low after an accept, and when o_valid first shows.
   task automatic measure(output int rl, output int lv);
      rl = 0;
      lv = -1;
      for (int c = 0; c < 300; c++) begin
         if (out_valid && lv < 0)
            lv = c;
         if (out_ready)
            break;
         rl++;
         tick();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int rl, lv, n0, v;
      rst = 1'b1; ena = 1'b1; cfg_load = 1'b0; cfg_dec = '0; cfg_taps = '0;
      cfg_shift = '0; coeff_we = 1'b0; coeff_addr = '0; coeff_data = '0;
      in_valid = 1'b0; in_data = '0;
      repeat (3) tick();
      rst = 1'b0;
      #1;
      chk("rst_valid", longint'(out_valid), 0);
      chk("rst_data", longint'(out_data), 0);
      chk("rst_sat", longint'(out_sat), 0);
      chk("rst_busy", longint'(out_busy), 0);
      chk("rst_ready", longint'(out_ready), 1);

      // Basic latency with the reset configuration.
      wr_coef(0, 1);
      send(5, rl);
      measure(rl, lv);
      chk("t1_lat", lv, 2);
      chk("t1_rdy_low", rl, 3);
      chk("t1_data", last_out, 5);
      chk("t1_sat", last_sat, 0);
      chk("t1_vld_fall", longint'(out_valid), 0);

      // Moving sum over 8 taps, one output per 4 samples.
      cfg(4, 2, 0);
      for (int k = 0; k < 8; k++) wr_coef(k, 1);
      n0 = n_out;
      for (int i = 0; i < 4; i++) send(3, rl);
      measure(rl, lv);
      chk("t2_first", last_out, 12);
      for (int i = 0; i < 12; i++) send(3, rl);
      measure(rl, lv);
      chk("t2_last", last_out, 24);
      chk("t2_count", n_out - n0, 4);

      // Saturation, large shift, then rounding with clamped D/T.
      cfg(2, 4, 0);
      for (int k = 0; k < 8; k++) wr_coef(k, -32768);
      for (int i = 0; i < 8; i++) send(-32, rl);
      measure(rl, lv);
      chk("t3_sat_data", last_out, 32767);
      chk("t3_sat_flag", last_sat, 1);
      cfg(2, 4, 10);
      for (int i = 0; i < 8; i++) send(-32, rl);
      measure(rl, lv);
      chk("t3_shift_data", last_out, 8192);
      chk("t3_shift_flag", last_sat, 0);
      cfg(0, 0, 1);
      wr_coef(0, 1);
      send(3, rl);
      measure(rl, lv);
      chk("t3_clamp_lat", lv, 2);
      chk("t3_rnd_pos", last_out, 2);
      send(-3, rl);
      measure(rl, lv);
      chk("t3_rnd_neg", last_out, -1);

      // Back-pressure with valid held high and random data.
      cfg(2, 3, 0);
      for (int k = 0; k < 6; k++) wr_coef(k, int'($urandom_range(0, 65535)));
      n0 = n_out;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         v = int'($urandom_range(0, 63)) - 32;
         in_data = 6'(v);
         wait_ready(rl);
         if (i > 0)
            chk("bp_rdy_low", rl, (i % 2 == 0) ? 8 : 0);
         tick();
      end
      in_valid = 1'b0;
      wait_ready(rl);
      chk("bp_rdy_low_end", rl, 8);
      repeat (3) tick();
      chk("bp_count", n_out - n0, 10);

      // Config/coefficient writes during MAC are dropped; enable stall delays output.
      cfg(2, 2, 0);
      for (int k = 0; k < 4; k++) wr_coef(k, k + 1);
      send(1, rl);
      send(2, rl);
      rl = 0;
      lv = -1;
      for (int c = 0; c < 300; c++) begin
         if (c == 0) begin
            cfg_load = 1'b1; cfg_dec = 6'd1; cfg_taps = 3'd1;
            coeff_we = 1'b1; coeff_addr = 7'd0; coeff_data = 16'd100;
         end
         if (c == 1) begin
            cfg_load = 1'b0; coeff_we = 1'b0; ena = 1'b0;
         end
         if (c == 6)
            ena = 1'b1;
         if (out_valid && lv < 0)
            lv = c;
         if (out_ready)
            break;
         rl++;
         tick();
      end
      chk("t6_stall_lat", lv, 10);
      chk("t6_stall_rdy", rl, 11);
      chk("t6_first", last_out, 4);
      send(3, rl);
      send(4, rl);
      measure(rl, lv);
      chk("t6_second", last_out, 20);

      // Reset in the middle of a MAC run.
      cfg(2, 4, 0);
      for (int k = 0; k < 8; k++) wr_coef(k, k + 1);
      send(10, rl);
      send(11, rl);
      repeat (3) tick();
      n0 = n_out;
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      #1;
      chk("t5_ready", longint'(out_ready), 1);
      chk("t5_busy", longint'(out_busy), 0);
      chk("t5_valid", longint'(out_valid), 0);
      chk("t5_data", longint'(out_data), 0);
      repeat (15) tick();
      chk("t5_no_out", n_out - n0, 0);
      send(17, rl);
      measure(rl, lv);
      chk("t5_lat", lv, 2);
      chk("t5_count", n_out - n0, 1);
      chk("t5_zero_coef", last_out, 0);

      repeat (20) tick();
      chk("sb_drain", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/filt_ppd_seq.md
Name: filt_ppd_seq

Overview:
Runtime-configurable polyphase decimation filter. It computes one output per D accepted input samples using a single time-multiplexed multiplier-accumulator over a D*T-tap delay line. The block adds valid/ready handshaking, a loadable coefficient bank, and a rounded, saturated output. It sits in the decimation chain after a modulator or CIC stage, in place of the fixed commutator plus parallel-multiplier decimator, wherever area matters more than throughput.

Parameters:
gp_idata_width, 6, signed input sample width
gp_coeff_width, 16, signed coefficient width
gp_max_decimation, 32, maximum decimation factor D
gp_max_taps_phase, 4, maximum taps per polyphase branch T
gp_odata_width, 16, signed output width after shift, round and saturate
gp_acc_width, gp_idata_width+gp_coeff_width+$clog2(gp_max_decimation*gp_max_taps_phase), accumulator width (derived)

Ports:
i_clk  in  1  rising-edge clock
i_rst  in  1  asynchronous active-high reset
i_ena  in  1  synchronous enable; low freezes all state
i_cfg_load  in  1  pulse: latch i_cfg_* values
i_cfg_dec  in  $clog2(gp_max_decimation+1)  decimation factor D
i_cfg_taps  in  $clog2(gp_max_taps_phase+1)  taps per phase T
i_cfg_shift  in  $clog2(gp_acc_width)  output right-shift S
i_coeff_we  in  1  coefficient write strobe
i_coeff_addr  in  $clog2(gp_max_decimation*gp_max_taps_phase)  coefficient index k
i_coeff_data  in  gp_coeff_width  signed coefficient h[k]
i_valid  in  1  input sample valid
i_data  in  gp_idata_width  signed input sample
o_ready  out  1  block can accept a sample
o_valid  out  1  one-cycle output strobe
o_data  out  gp_odata_width  signed filter output
o_sat  out  1  o_data was clipped; qualified by o_valid
o_busy  out  1  MAC or output stage active

Behaviour:
- Reset (asynchronous, i_rst=1): o_valid=0, o_data=0, o_sat=0, o_busy=0. Delay line, coefficients, phase counter and accumulator are cleared. Configuration resets to D=1, T=1, S=0. FSM enters IDLE.
- i_ena=0: every register holds its value and o_ready=0. The FSM resumes exactly where it stopped.
- o_ready = (state==IDLE) & i_ena & ~i_rst. A sample is accepted when i_valid & o_ready.
- Delay line x[0..N-1], N=D*T: on accept, x[0] takes the new sample and x[k] shifts to x[k+1]. Coefficient h[k] multiplies x[k], so h[0] applies to the newest sample.
- The phase counter counts accepted samples modulo D. The accept that wraps the counter to 0 (the D-th sample) moves the FSM from IDLE to MAC, with acc=0 and k=0.
- FSM states:
  - IDLE: wait for the D-th accepted sample.
  - MAC: exactly N cycles; each edge performs acc += x[k]*h[k] and k++; the state exits after k=N-1.
  - OUT: registers o_data/o_sat and sets o_valid=1 for exactly one cycle, then returns to IDLE.
- Timing: if accept edge e0, MACs occur on e1..eN, o_valid rises at eN+1 and falls at eN+2. o_ready is low for N+2 cycles. o_busy=1 in MAC and OUT.
- Arithmetic: products are full precision, sign-extended into gp_acc_width.
  - Output = (acc + (S>0 ? 2^(S-1) : 0)) >>> S, i.e. round-half-up with arithmetic shift.
  - The result saturates to [-2^(gp_odata_width-1), 2^(gp_odata_width-1)-1]. o_sat=1 when clipping occurs.
  - o_data holds its value between strobes.
- Configuration:
  - i_cfg_load is honoured only in IDLE; it is ignored while o_busy=1.
  - A load clears the delay line and the phase counter.
  - Clamping: D=0 is treated as 1 and D>gp_max_decimation as max; T is clamped the same way.
- Coefficient writes are honoured when state==IDLE. Writes during MAC/OUT are dropped so the computation is never corrupted. An address >= gp_max_decimation*gp_max_taps_phase is ignored.
- Simultaneous i_cfg_load and sample accept: the load wins and the sample is discarded.
- Simultaneous coefficient write and accept are both performed.
- Reset asserted mid-MAC or mid-OUT: the pending output is never emitted, and o_ready=1 on the first enabled cycle after release.

Test Plan:
- Reset, D=1,T=1,S=0, h[0]=1, i_data=5 accepted at e0 -> o_valid=1 at e2 with o_data=5, o_sat=0; o_ready low 3 cycles.
- D=4,T=2,S=0, h[0..7]=1, constant input 3 -> first o_data=12 (zero-filled line), then 24 on every 4th accept; 0 outputs between.
- Saturation/rounding: D=2,T=4, h=-32768, input -32 -> acc=8388608, S=0 -> o_data=32767, o_sat=1. Same with S=10 -> o_data=8192, o_sat=0. Accumulator 3 with S=1 -> 2; accumulator -3 with S=1 -> -1.
- Back-pressure: D=2,T=3, i_valid held high, 20 input samples -> o_ready low 8 cycles after each 2nd accept; no sample lost or duplicated; 10 outputs match the reference model.
- i_rst pulsed during MAC -> no o_valid; after release, outputs equal zero, o_ready=1, coefficients zero, D=1.
- i_cfg_load and i_coeff_we during MAC -> ignored; the current output and the next output use the old configuration and coefficients; i_ena low for 5 cycles mid-MAC -> o_valid delayed by exactly 5 cycles, same value.
